// File: rtl/gcd_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gcd_arbiter_if : request/response bundle between clients and gcd_arbiter |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface gcd_arbiter_if #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int CNTW = 10
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]    req_valid;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_b;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IDW-1:0]  rsp_id;
    logic [W-1:0]    rsp_data;
    logic [CNTW-1:0] rsp_cycles;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_cycles
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_cycles
    );
endinterface
`default_nettype wire

// File: rtl/gcd_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gcd_arbiter : round-robin sharing of one subtract/swap GCD engine        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module gcd_arbiter #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int CNTW = 10
) (
    input  logic         clk,
    input  logic         nrst,
    gcd_arbiter_if.slave bus,
    output logic         gcd_start,
    output logic [W-1:0] gcd_ina,
    output logic [W-1:0] gcd_inb,
    input  logic         gcd_ready,
    input  logic [W-1:0] gcd_out
);
    localparam int              IDW     = $clog2(N);
    localparam logic [CNTW-1:0] CYC_MAX = '1;
    localparam logic [CNTW-1:0] CYC_ONE = CNTW'(1);
    localparam logic [IDW-1:0]  ID_LAST = IDW'(N - 1);
    localparam logic [IDW-1:0]  ID_ONE  = IDW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  cur_id;
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic [CNTW-1:0] cyc;

    logic            grant_any;
    logic            grant_go;
    logic [IDW-1:0]  grant_idx;
    logic [W-1:0]    grant_a;
    logic [W-1:0]    grant_b;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return IDW'(s);
    endfunction

    // Scan from rr_ptr upward; the first valid requester found wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = rr_ptr;
        for (int k = 0; k < N; k++) begin
            if (!grant_any && bus.req_valid[wrap_add(rr_ptr, k)]) begin
                grant_any = 1'b1;
                grant_idx = wrap_add(rr_ptr, k);
            end
        end
    end

    assign grant_go      = (state == IDLE) && gcd_ready && grant_any;
    assign grant_a       = bus.req_a[grant_idx*W +: W];
    assign grant_b       = bus.req_b[grant_idx*W +: W];
    assign bus.req_ready = grant_go ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;

    assign gcd_start = (state == ISSUE);
    assign gcd_ina   = op_a;
    assign gcd_inb   = op_b;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            cur_id         <= '0;
            op_a           <= '0;
            op_b           <= '0;
            cyc            <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= '0;
            bus.rsp_data   <= '0;
            bus.rsp_cycles <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_go) begin
                        op_a   <= grant_a;
                        op_b   <= grant_b;
                        cur_id <= grant_idx;
                        rr_ptr <= (grant_idx == ID_LAST) ? '0 : grant_idx + ID_ONE;
                        // A zero operand would make the engine subtract forever.
                        if (grant_a == '0 || grant_b == '0) begin
                            bus.rsp_data   <= grant_a | grant_b;
                            bus.rsp_cycles <= '0;
                            bus.rsp_id     <= grant_idx;
                            bus.rsp_valid  <= 1'b1;
                            state          <= RESP;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    cyc   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (cyc != CYC_MAX) cyc <= cyc + CYC_ONE;
                    if (gcd_ready) begin
                        bus.rsp_data   <= gcd_out;
                        bus.rsp_cycles <= (cyc == CYC_MAX) ? CYC_MAX : cyc + CYC_ONE;
                        bus.rsp_id     <= cur_id;
                        bus.rsp_valid  <= 1'b1;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_gcd_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gcd_arbiter : bench for gcd_arbiter with a subtract/swap engine model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_gcd_arbiter;
    localparam int N    = 4;
    localparam int W    = 8;
    localparam int CNTW = 10;

    logic         clk  = 1'b0;
    logic         nrst = 1'b0;
    logic         gcd_start;
    logic         gcd_ready;
    logic [W-1:0] gcd_ina;
    logic [W-1:0] gcd_inb;
    logic [W-1:0] gcd_out;
    logic [W-1:0] eng_a;
    logic [W-1:0] eng_b;

    gcd_arbiter_if #(.N(N), .W(W), .CNTW(CNTW)) bus ();

    gcd_arbiter #(.N(N), .W(W), .CNTW(CNTW)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .bus       (bus),
        .gcd_start (gcd_start),
        .gcd_ina   (gcd_ina),
        .gcd_inb   (gcd_inb),
        .gcd_ready (gcd_ready),
        .gcd_out   (gcd_out)
    );

    always #5 clk = ~clk;

    // Engine: load on start, else swap when a<b, else a-=b, until a==b.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            eng_a <= '0;
            eng_b <= '0;
        end else if (gcd_start) begin
            eng_a <= gcd_ina;
            eng_b <= gcd_inb;
        end else if (eng_a < eng_b) begin
            eng_a <= eng_b;
            eng_b <= eng_a;
        end else if (eng_a != eng_b) begin
            eng_a <= eng_a - eng_b;
        end
    end
    assign gcd_ready = (eng_a == eng_b);
    assign gcd_out   = eng_a;

    typedef struct {
        int              id;
        logic [W-1:0]    data;
        logic [CNTW-1:0] cycles;
    } exp_t;

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_data;
        int           exp_cycles;
        int           exp_starts;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    int   accept_cnt = 0;
    int   rsp_cnt = 0;
    int   start_cnt = 0;
    bit   rand_rdy = 1'b0;
    exp_t sb[$];
    int   grant_log[$];
    int   last_id;
    logic [W-1:0]    last_data;
    logic [CNTW-1:0] last_cycles;
    logic [W-1:0]    mon_a;
    logic [W-1:0]    mon_b;
    exp_t            mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [CNTW-1:0] ref_cycles(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        int n;
        if (a == 0 || b == 0) return '0;
        x = a;
        y = b;
        n = 1;
        while (x != y) begin
            if (x < y) begin
                t = x; x = y; y = t;
            end else begin
                x = x - y;
            end
            n++;
        end
        return (n >= (1 << CNTW)) ? '1 : CNTW'(n);
    endfunction

    // Accepts push expectations; response handshakes pop and compare.
    always @(negedge clk) begin
        if (nrst) begin
            if (bus.req_ready != '0)
                check("req_ready_onehot", 64'($onehot(bus.req_ready)), 64'd1);
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    accept_cnt++;
                    grant_log.push_back(i);
                    mon_a = bus.req_a[i*W +: W];
                    mon_b = bus.req_b[i*W +: W];
                    mon_e.id     = i;
                    mon_e.data   = ref_gcd(mon_a, mon_b);
                    mon_e.cycles = ref_cycles(mon_a, mon_b);
                    sb.push_back(mon_e);
                end
            end
            if (gcd_start) start_cnt++;
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected: got id %0d data %0d expected no response",
                             bus.rsp_id, bus.rsp_data);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_id", 64'(bus.rsp_id), 64'(mon_e.id));
                    check("rsp_data", 64'(bus.rsp_data), 64'(mon_e.data));
                    check("rsp_cycles", 64'(bus.rsp_cycles), 64'(mon_e.cycles));
                    last_id     = int'(bus.rsp_id);
                    last_data   = bus.rsp_data;
                    last_cycles = bus.rsp_cycles;
                end
            end
        end
    end

    task automatic send(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok = 1'b0;
        bus.req_a[id*W +: W] = a;
        bus.req_b[id*W +: W] = b;
        bus.req_valid[id]    = 1'b1;
        for (int t = 0; t < 2000 && !ok; t++) begin
            @(negedge clk);
            if (bus.req_ready[id]) ok = 1'b1;
            @(posedge clk);
            #1;
            if (rand_rdy) bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        bus.req_valid[id] = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: requester %0d not granted, expected a grant", id);
        end
    endtask

    task automatic wait_idle(input int bound);
        bit done = 1'b0;
        for (int t = 0; t < bound && !done; t++) begin
            @(posedge clk);
            #1;
            bus.rsp_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rsp_cnt == accept_cnt && !bus.rsp_valid) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: responses %0d expected %0d", rsp_cnt, accept_cnt);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rsp"}, {bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_cycles}, '0);
        check({tag, "_eng"}, {gcd_start, bus.req_ready, gcd_ina, gcd_inb}, '0);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        nrst = 1'b0;
        sb.delete();
        rsp_cnt = accept_cnt;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    vec_t vecs[8];
    int   order[5] = '{0, 1, 2, 3, 0};

    initial begin
        int s0, a0;
        logic [W-1:0] ra, rb;

        vecs[0] = '{0, 8'd48,  8'd18,  8'd6,  7,   1};
        vecs[1] = '{2, 8'd9,   8'd9,   8'd9,  1,   1};
        vecs[2] = '{1, 8'd0,   8'd12,  8'd12, 0,   0};
        vecs[3] = '{1, 8'd0,   8'd0,   8'd0,  0,   0};
        vecs[4] = '{3, 8'd12,  8'd0,   8'd12, 0,   0};
        vecs[5] = '{2, 8'd100, 8'd75,  8'd25, 5,   1};
        vecs[6] = '{3, 8'd21,  8'd14,  8'd7,  4,   1};
        vecs[7] = '{1, 8'd1,   8'd255, 8'd1,  256, 1};

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset_init");
        @(posedge clk);
        #1;
        nrst = 1'b1;

        // Single requests, one at a time.
        foreach (vecs[v]) begin
            s0 = start_cnt;
            a0 = accept_cnt;
            send(vecs[v].id, vecs[v].a, vecs[v].b);
            wait_idle(600);
            check("vec_accepts", 64'(accept_cnt - a0), 64'd1);
            check("vec_starts", 64'(start_cnt - s0), 64'(vecs[v].exp_starts));
            check("vec_id", 64'(last_id), 64'(vecs[v].id));
            check("vec_data", 64'(last_data), 64'(vecs[v].exp_data));
            check("vec_cycles", 64'(last_cycles), 64'(vecs[v].exp_cycles));
        end

        // All requesters continuously valid: round-robin order.
        apply_reset();
        grant_log.delete();
        a0 = accept_cnt;
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*W +: W] = W'((i + 2) * 6);
            bus.req_b[i*W +: W] = 8'd4;
        end
        bus.req_valid = '1;
        for (int t = 0; t < 3000 && accept_cnt < a0 + 5; t++) begin
            @(posedge clk);
            #1;
        end
        bus.req_valid = '0;
        wait_idle(600);
        check("rr_grant_count", 64'(grant_log.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            if (grant_log.size() > k) check("rr_order", 64'(grant_log[k]), 64'(order[k]));
        end

        // Backpressure: response held, no new grant while held.
        bus.rsp_ready = 1'b0;
        send(2, 8'd255, 8'd1);
        for (int t = 0; t < 400 && !bus.rsp_valid; t++) begin
            @(posedge clk);
            #1;
        end
        bus.req_a[1*W +: W] = 8'd5;
        bus.req_b[1*W +: W] = 8'd10;
        bus.req_valid[1]    = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk);
            #1;
            check("hold_outputs", {bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_cycles},
                  {1'b1, 2'd2, 8'd1, 10'd255});
            check("hold_no_grant", 64'(bus.req_ready), 64'd0);
        end
        bus.req_valid[1] = 1'b0;
        bus.rsp_ready    = 1'b1;
        wait_idle(100);
        check("hold_release_data", 64'(last_data), 64'd1);

        // Reset during WAIT aborts the operation.
        send(0, 8'd200, 8'd3);
        repeat (3) @(posedge clk);
        #1;
        check("wait_state", {gcd_start, bus.rsp_valid, gcd_ina}, {1'b0, 1'b0, 8'd200});
        nrst = 1'b0;
        sb.delete();
        rsp_cnt = accept_cnt;
        #1;
        check_reset_state("reset_midop");
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        send(1, 8'd21, 8'd14);
        wait_idle(600);
        check("post_reset_data", 64'(last_data), 64'd7);
        check("post_reset_id", 64'(last_id), 64'd1);

        // Random operands, requesters and backpressure.
        rand_rdy = 1'b1;
        a0 = accept_cnt;
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) ra = '0;
            if ($urandom_range(0, 15) == 0) rb = '0;
            send(int'($urandom_range(0, N - 1)), ra, rb);
        end
        wait_idle(2000);
        rand_rdy = 1'b0;
        bus.rsp_ready = 1'b1;
        check("rand_accepts", 64'(accept_cnt - a0), 64'd1000);
        check("rand_all_responded", 64'(rsp_cnt), 64'(accept_cnt));
        check("rand_sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
